// File: rtl/axis_frame_reader_pkg.sv
// Shared encodings for the frame-stream cores: status/error codes, the
// FIFO depth of the pixel source and the pixel word carried through it.
package axis_frame_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_DONE  = 2'd2,
    ST_ERROR = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_TIMEOUT = 2'd1,
    ERR_ABORT   = 2'd2
  } err_t;

  // Output FIFO depth; also the number of read credits the source may hold.
  localparam int FIFO_DEPTH = 2;

  // One pixel beat: data plus end-of-frame marker.
  typedef struct packed {
    logic       last;
    logic [7:0] data;
  } pix_t;

endpackage

// File: rtl/axis_frame_reader_pix_fifo2.sv
// Two-entry pixel FIFO. The head slot is a register, so the stream outputs
// taken from it carry no combinational path from push/pop inputs.
module pix_fifo2
  import axis_frame_reader_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  pix_t       push_pix,
  input  logic       pop,
  input  logic       flush,
  output logic [1:0] count,
  output logic       head_valid,
  output pix_t       head_pix
);

  logic       wr_ptr_reg;
  logic       rd_ptr_reg;
  logic [1:0] count_reg;
  logic       do_push;
  logic       do_pop;

  // Pop of an empty FIFO is ignored; a push into a full FIFO only lands
  // when the head leaves in the same cycle.
  assign do_pop  = pop && (count_reg != 2'd0);
  assign do_push = push && ((count_reg != 2'd2) || do_pop);

  genvar gi;
  generate
    for (gi = 0; gi < FIFO_DEPTH; gi++) begin : g_slot
      pix_t slot_reg;

      // Capture the incoming pixel when this slot is the write target.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          slot_reg <= '0;
        end else if (do_push && !flush && (wr_ptr_reg == 1'(gi))) begin
          slot_reg <= push_pix;
        end
      end
    end
  endgenerate

  // Pointer and occupancy bookkeeping; flush empties the FIFO at once.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= ~wr_ptr_reg;
      end
      if (do_pop) begin
        rd_ptr_reg <= ~rd_ptr_reg;
      end
      count_reg <= count_reg + 2'(do_push) - 2'(do_pop);
    end
  end

  assign count      = count_reg;
  assign head_valid = (count_reg != 2'd0);
  assign head_pix   = rd_ptr_reg ? g_slot[1].slot_reg : g_slot[0].slot_reg;

endmodule

// File: rtl/axis_frame_reader.sv
// AXI4-Stream frame source: reads a W x H frame from a synchronous-read
// buffer in raster order and streams it out, with start/status/err_code
// control matching the downstream filter cores.
module axis_frame_reader
  import axis_frame_reader_pkg::*;
#(
  parameter int W               = 512,
  parameter int H               = 512,
  parameter int TOTAL_PIXEL     = W * H,
  parameter int TOTAL_PIXEL_BIT = $clog2(W * H),
  parameter int TIME_LIMIT      = 1_000_000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       abort,
  output logic [1:0]                 status,
  output logic [1:0]                 err_code,
  output logic                       mem_rd_en,
  output logic [TOTAL_PIXEL_BIT-1:0] mem_addr,
  input  logic [7:0]                 mem_rdata,
  output logic [7:0]                 m_axis_tdata,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic                       m_axis_tlast
);

  // The read address needs one extra bit so it can sit at TOTAL_PIXEL
  // once every pixel has been issued.
  localparam int AW = TOTAL_PIXEL_BIT + 1;
  localparam int SW = $clog2(TIME_LIMIT + 1);
  localparam logic [AW-1:0] LAST_ADDR  = AW'(TOTAL_PIXEL - 1);
  localparam logic [AW-1:0] END_ADDR   = AW'(TOTAL_PIXEL);
  localparam logic [SW-1:0] STALL_TRIP = SW'(TIME_LIMIT - 1);

  state_t          state_reg, state_next;
  err_t            err_reg, err_next;
  logic [AW-1:0]   rd_addr_reg;
  logic            inflight_reg;
  logic            inflight_last_reg;
  logic [SW-1:0]   stall_cnt_reg;

  logic [1:0]      fifo_count;
  logic            fifo_valid;
  pix_t            head_pix;
  pix_t            push_pix;

  logic            busy;
  logic            handshake;
  logic            stalled;
  logic            timeout_hit;
  logic            launch;
  logic            leave_busy;
  logic            flush;
  logic            issue;
  logic [2:0]      credits_used;

  assign busy      = (state_reg == ST_BUSY);
  assign handshake = fifo_valid && m_axis_tready;
  assign stalled   = fifo_valid && !m_axis_tready;
  // The counter trips on the cycle that would bring it to TIME_LIMIT.
  assign timeout_hit = stalled && (stall_cnt_reg == STALL_TRIP);
  assign launch      = (state_reg != ST_BUSY) && start;

  // Reads held = FIFO entries + read in flight, less the beat leaving now.
  // Counting the departing beat keeps one read per cycle going with
  // tready high while never holding more than FIFO_DEPTH reads.
  assign credits_used = 3'(fifo_count) + 3'(inflight_reg) - 3'(handshake);
  assign issue = busy && (rd_addr_reg < END_ADDR) &&
                 (credits_used < 3'(FIFO_DEPTH));

  // Next-state and error-code selection; abort outranks the last beat and
  // the stall timeout.
  always_comb begin
    state_next = state_reg;
    err_next   = err_reg;
    case (state_reg)
      ST_BUSY: begin
        if (abort) begin
          state_next = ST_ERROR;
          err_next   = ERR_ABORT;
        end else if (handshake && head_pix.last) begin
          state_next = ST_DONE;
        end else if (timeout_hit) begin
          state_next = ST_ERROR;
          err_next   = ERR_TIMEOUT;
        end
      end
      default: begin
        if (start) begin
          state_next = ST_BUSY;
          err_next   = ERR_NONE;
        end
      end
    endcase
  end

  assign leave_busy = busy && (state_next != ST_BUSY);
  assign flush      = launch || leave_busy;

  // FSM and error-code registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      err_reg   <= ERR_NONE;
    end else begin
      state_reg <= state_next;
      err_reg   <= err_next;
    end
  end

  // Raster read address: restarts on every launch, no wrap.
  always_ff @(posedge clk) begin
    if (!rst_n || launch) begin
      rd_addr_reg <= '0;
    end else if (issue) begin
      rd_addr_reg <= rd_addr_reg + AW'(1);
    end
  end

  // Track the read whose data returns next cycle; dropped on flush so that
  // data from an abandoned frame never reaches the FIFO.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      inflight_reg      <= 1'b0;
      inflight_last_reg <= 1'b0;
    end else begin
      inflight_reg      <= issue;
      inflight_last_reg <= (rd_addr_reg == LAST_ADDR);
    end
  end

  // Consecutive stalled-beat counter.
  always_ff @(posedge clk) begin
    if (!rst_n || !busy || handshake || leave_busy) begin
      stall_cnt_reg <= '0;
    end else if (stalled) begin
      stall_cnt_reg <= stall_cnt_reg + SW'(1);
    end
  end

  assign push_pix = '{last: inflight_last_reg, data: mem_rdata};

  pix_fifo2 u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (inflight_reg),
    .push_pix   (push_pix),
    .pop        (handshake),
    .flush      (flush),
    .count      (fifo_count),
    .head_valid (fifo_valid),
    .head_pix   (head_pix)
  );

  assign status        = state_reg;
  assign err_code      = err_reg;
  assign mem_rd_en     = issue;
  assign mem_addr      = rd_addr_reg[TOTAL_PIXEL_BIT-1:0];
  assign m_axis_tdata  = head_pix.data;
  assign m_axis_tvalid = fifo_valid;
  assign m_axis_tlast  = head_pix.last;

endmodule
